mux_nx1_rr: RTL and testbench

- N-to-1 streaming multiplexer with round-robin arbitration. It is the gather-side counterpart of the 1xN demux.
- Merges N valid/ready input channels onto one registered output channel.
- Tags each output beat with the index of its source channel.
- Sits wherever several producers share one consumer, such as a shared bus or display/UART sink.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/mux_nx1_rr_arbiter.sv | 40 ++++
 rtl/mux_nx1_rr.sv | 89 ++++++++
 tb/tb_mux_nx1_rr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 1xN demux / Nx1 mux streaming pair.
// Holds the output-register state encoding and the default channel geometry.
package mux_pkg;

    localparam int MUX_N_DEF = 8;
    localparam int MUX_W_DEF = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_st_e;

    // Index width for v entries, never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// Round-robin grant: the first requester after 'last', searching upward modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = MUX_N_DEF,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic [N-1:0]    gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    int             start;
    int             off;
    int             idx;

    always_comb begin
        start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
        // Doubling the request vector turns the modulo search into a plain window.
        req2  = {req, req};
        rot   = req2[start +: N];
        off   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        idx = start + off;
        if (idx >= N) idx = idx - N;
        gnt_any    = |req;
        gnt_idx    = gnt_any ? SELW'(idx) : '0;
        gnt_onehot = '0;
        if (gnt_any) gnt_onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-to-1 round-robin stream merge; each output beat is tagged with its source index.
// Latency: 1 cycle from input transfer to out_*; sustains one beat per cycle.
// Backpressure: out_ready low while full stalls the register and drops every in_ready.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int N    = MUX_N_DEF,
    parameter int W    = MUX_W_DEF,
    parameter int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    out_st_e         st_q, st_d;
    logic [W-1:0]    dat_q, dat_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] last_q, last_d;

    logic [N-1:0]    gnt_onehot;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            can_accept;
    logic            in_xfer;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req        (in_valid),
        .last       (last_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_comb begin
        can_accept = (st_q == ST_EMPTY) || out_ready;
        in_xfer    = gnt_any && can_accept;
        // Held low during reset so no source believes a beat was taken.
        in_ready   = gnt_onehot & {N{can_accept && rst_n}};

        st_d   = st_q;
        dat_d  = dat_q;
        sel_d  = sel_q;
        last_d = last_q;
        if (in_xfer) begin
            st_d   = ST_FULL;
            dat_d  = in_data[int'(gnt_idx)*W +: W];
            sel_d  = gnt_idx;
            last_d = gnt_idx;
        end else if ((st_q == ST_FULL) && out_ready) begin
            st_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_EMPTY;
            dat_q  <= '0;
            sel_q  <= '0;
            last_q <= SELW'(N - 1);
        end else begin
            st_q   <= st_d;
            dat_q  <= dat_d;
            sel_q  <= sel_d;
            last_q <= last_d;
        end
    end

    assign out_valid = (st_q == ST_FULL);
    assign out_data  = dat_q;
    assign out_sel   = sel_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));
    a_sel_range: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (int'(out_sel) < N));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: vector table on an N=8 instance plus
// hand sequences on N=6 (wrap/skip) and N=1 (plain pipeline register).
module tb_mux_nx1_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // N=8 instance
    logic [7:0]  iv8 = '0;
    logic [63:0] id8;
    logic [7:0]  ir8;
    logic        ov8;
    logic [7:0]  od8;
    logic [2:0]  os8;
    logic        ordy8 = 1'b1;

    // N=6 instance
    logic [5:0]  iv6 = '0;
    logic [47:0] id6;
    logic [5:0]  ir6;
    logic        ov6;
    logic [7:0]  od6;
    logic [2:0]  os6;
    logic        ordy6 = 1'b1;

    // N=1 instance
    logic [0:0]  iv1 = '0;
    logic [7:0]  id1 = 8'h00;
    logic [0:0]  ir1;
    logic        ov1;
    logic [7:0]  od1;
    logic [0:0]  os1;
    logic        ordy1 = 1'b1;

    mux_nx1_rr #(.N(8), .W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_data(id8), .in_ready(ir8),
        .out_valid(ov8), .out_data(od8), .out_sel(os8), .out_ready(ordy8));

    mux_nx1_rr #(.N(6), .W(8)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_data(id6), .in_ready(ir6),
        .out_valid(ov6), .out_data(od6), .out_sel(os6), .out_ready(ordy6));

    mux_nx1_rr #(.N(1), .W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1));

    typedef struct {
        logic       rst;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] d3;
        logic [7:0] eir;
        logic       eov;
        logic [2:0] esel;
        logic [7:0] edat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [7:0] iv, input logic ordy,
                       input logic [7:0] d3, input logic [7:0] eir, input logic eov,
                       input logic [2:0] esel, input logic [7:0] edat);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ordy = ordy; v.d3 = d3;
        v.eir = eir; v.eov = eov; v.esel = esel; v.edat = edat;
        vq.push_back(v);
    endtask

    task automatic step6(input logic [5:0] iv, input logic ordy, input logic [5:0] eir,
                         input logic eov, input logic [2:0] esel, input logic [7:0] edat);
        @(negedge clk);
        iv6 = iv; ordy6 = ordy;
        #1;
        chk("n6 in_ready",  32'(ir6), 32'(eir));
        chk("n6 out_valid", 32'(ov6), 32'(eov));
        chk("n6 out_sel",   32'(os6), 32'(esel));
        chk("n6 out_data",  32'(od6), 32'(edat));
        chk("n6 sel range", 32'(os6 < 3'd6), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) id8[i*8 +: 8] = 8'(8'h10 + i);
        for (int i = 0; i < 6; i++) id6[i*8 +: 8] = 8'(8'h60 + i);

        // Single source on channel 3, then drain.
        add(1, 8'h00, 1, 8'hA5, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h00, 1, 8'hA5, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h08, 1, 8'hA5, 8'h08, 0, 3'd0, 8'h00);
        add(0, 8'h00, 1, 8'hA5, 8'h00, 1, 3'd3, 8'hA5);
        add(0, 8'h00, 1, 8'hA5, 8'h00, 0, 3'd3, 8'hA5);

        // All eight valid: in_ready must stay 0 in reset, then 0..7,0,1 with no bubbles.
        add(1, 8'hFF, 1, 8'h13, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'hFF, 1, 8'h13, 8'h01, 0, 3'd0, 8'h00);
        for (int k = 1; k <= 10; k++)
            add(0, 8'hFF, 1, 8'h13, 8'(1 << (k % 8)), 1, 3'((k - 1) % 8), 8'(8'h10 + (k - 1) % 8));

        // Backpressure with channels 1 and 5.
        add(1, 8'h22, 1, 8'h13, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h22, 1, 8'h13, 8'h02, 0, 3'd0, 8'h00);
        for (int k = 0; k < 4; k++)
            add(0, 8'h22, 0, 8'h13, 8'h00, 1, 3'd1, 8'h11);
        add(0, 8'h22, 1, 8'h13, 8'h20, 1, 3'd1, 8'h11);
        add(0, 8'h22, 1, 8'h13, 8'h02, 1, 3'd5, 8'h15);
        add(0, 8'h00, 1, 8'h13, 8'h00, 1, 3'd1, 8'h11);
        add(0, 8'h00, 1, 8'h13, 8'h00, 0, 3'd1, 8'h11);

        // Reset while full with out_sel=2; checked before the next rising edge.
        add(1, 8'h00, 1, 8'h13, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h04, 1, 8'h13, 8'h04, 0, 3'd0, 8'h00);
        add(0, 8'h05, 0, 8'h13, 8'h00, 1, 3'd2, 8'h12);
        add(1, 8'h05, 0, 8'h13, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h05, 1, 8'h13, 8'h01, 0, 3'd0, 8'h00);
        add(0, 8'h05, 1, 8'h13, 8'h04, 1, 3'd0, 8'h10);
        add(0, 8'h00, 1, 8'h13, 8'h00, 1, 3'd2, 8'h12);

        // Channel 6 pulses valid during a stall and withdraws before it is served.
        add(1, 8'h00, 1, 8'h13, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h0A, 1, 8'h13, 8'h02, 0, 3'd0, 8'h00);
        add(0, 8'h4A, 0, 8'h13, 8'h00, 1, 3'd1, 8'h11);
        add(0, 8'h0A, 0, 8'h13, 8'h00, 1, 3'd1, 8'h11);
        add(0, 8'h0A, 1, 8'h13, 8'h08, 1, 3'd1, 8'h11);
        add(0, 8'h0A, 1, 8'h13, 8'h02, 1, 3'd3, 8'h13);
        add(0, 8'h00, 1, 8'h13, 8'h00, 1, 3'd1, 8'h11);
        add(0, 8'h00, 1, 8'h13, 8'h00, 0, 3'd1, 8'h11);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n = !vq[i].rst;
            iv8   = vq[i].iv;
            ordy8 = vq[i].ordy;
            id8[3*8 +: 8] = vq[i].d3;
            #1;
            chk($sformatf("v%0d in_ready", i),  32'(ir8), 32'(vq[i].eir));
            chk($sformatf("v%0d out_valid", i), 32'(ov8), 32'(vq[i].eov));
            chk($sformatf("v%0d out_sel", i),   32'(os8), 32'(vq[i].esel));
            chk($sformatf("v%0d out_data", i),  32'(od8), 32'(vq[i].edat));
        end
        @(negedge clk);
        iv8 = '0;

        // N=6: channels 0 and 4 from last=4 alternate; then wrap from channel 5 to 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step6(6'h10, 1, 6'h10, 0, 3'd0, 8'h00);
        step6(6'h11, 1, 6'h01, 1, 3'd4, 8'h64);
        step6(6'h11, 1, 6'h10, 1, 3'd0, 8'h60);
        step6(6'h11, 1, 6'h01, 1, 3'd4, 8'h64);
        step6(6'h00, 1, 6'h00, 1, 3'd0, 8'h60);
        step6(6'h20, 1, 6'h20, 0, 3'd0, 8'h60);
        step6(6'h01, 1, 6'h01, 1, 3'd5, 8'h65);
        step6(6'h00, 1, 6'h00, 1, 3'd0, 8'h60);

        // N=1: one-deep pipeline register, out_sel always 0.
        @(negedge clk);
        iv1 = 1'b1; id1 = 8'h3C; ordy1 = 1'b1;
        #1;
        chk("n1 in_ready",  32'(ir1), 32'd1);
        chk("n1 out_valid idle", 32'(ov1), 32'd0);
        @(negedge clk);
        iv1 = 1'b0;
        #1;
        chk("n1 out_valid", 32'(ov1), 32'd1);
        chk("n1 out_data",  32'(od1), 32'h3C);
        chk("n1 out_sel",   32'(os1), 32'd0);
        @(negedge clk);
        #1;
        chk("n1 drained", 32'(ov1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
